// File: rtl/check_seq_pkg.sv
// Shared types and widths for the check sequencer.
package check_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CNT_W  = 16;
   localparam int FAIL_W = 8;

endpackage

// File: rtl/check_sequencer_rr_arbiter.sv
// Round-robin pick: first set request bit searching upward from ptr+1, wrapping.
module rr_arbiter #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] grant_id,
   output logic           grant_valid
);

   logic [IDW-1:0] w_idx;

   // Walk the N candidates in priority order; the first hit wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      w_idx       = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = IDW'((int'(ptr) + 1 + k) % N);
         if (!grant_valid && req[w_idx]) begin
            grant_valid = 1'b1;
            grant_id    = w_idx;
         end
      end
   end

endmodule

// File: rtl/check_sequencer.sv
// Serializes self-check requests onto one compare unit and keeps run statistics.
module check_sequencer
   import check_seq_pkg::*;
#(
   parameter  int N   = 4,
   parameter  int W   = 8,
   localparam int IDW = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic [N*W-1:0]    exp_data,
   input  logic [N*W-1:0]    act_data,
   input  logic              end_req,
   output logic [N-1:0]      ack,
   output logic              busy,
   output logic [CNT_W-1:0]  check_count,
   output logic [FAIL_W-1:0] fail_count,
   output logic [IDW-1:0]    first_fail_id,
   output logic [W-1:0]      first_fail_act,
   output logic              done,
   output logic              passed
);

   state_t            r_state, w_next_state;
   logic [IDW-1:0]    r_ptr, r_id;
   logic [W-1:0]      r_exp_hold, r_act_hold;
   logic              r_mismatch;
   logic [CNT_W-1:0]  r_check_count;
   logic [FAIL_W-1:0] r_fail_count;
   logic [IDW-1:0]    r_ff_id;
   logic [W-1:0]      r_ff_act;
   logic [IDW-1:0]    w_grant_id;
   logic              w_grant_valid;

   rr_arbiter #(.N(N)) u_arb (
      .req         (req),
      .ptr         (r_ptr),
      .grant_id    (w_grant_id),
      .grant_valid (w_grant_valid)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next state: a pending request beats end_req; DONE only leaves on reset.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) w_next_state = GRANT;
            else if (end_req)  w_next_state = DONE;
         end
         GRANT:   w_next_state = CHECK;
         CHECK:   w_next_state = IDLE;
         DONE:    w_next_state = DONE;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      ack    = '0;
      busy   = 1'b0;
      done   = 1'b0;
      passed = 1'b0;
      case (r_state)
         GRANT: begin
            ack[r_id] = 1'b1;
            busy      = 1'b1;
         end
         CHECK: busy = 1'b1;
         DONE: begin
            done   = 1'b1;
            passed = (r_fail_count == '0);
         end
         default: ;
      endcase
   end

   // Grant capture, 4-state compare and saturating statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr         <= IDW'(N - 1);
         r_id          <= '0;
         r_exp_hold    <= '0;
         r_act_hold    <= '0;
         r_mismatch    <= 1'b0;
         r_check_count <= '0;
         r_fail_count  <= '0;
         r_ff_id       <= '0;
         r_ff_act      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_id       <= w_grant_id;
                  r_ptr      <= w_grant_id;
                  r_exp_hold <= exp_data[int'(w_grant_id)*W +: W];
                  r_act_hold <= act_data[int'(w_grant_id)*W +: W];
               end
            end
            // x/z bits only match when identical in both operands.
            GRANT: r_mismatch <= (r_act_hold !== r_exp_hold);
            CHECK: begin
               if (r_check_count != '1) r_check_count <= r_check_count + 1'b1;
               if (r_mismatch) begin
                  if (r_fail_count == '0) begin
                     r_ff_id  <= r_id;
                     r_ff_act <= r_act_hold;
                  end
                  if (r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign check_count    = r_check_count;
   assign fail_count     = r_fail_count;
   assign first_fail_id  = r_ff_id;
   assign first_fail_act = r_ff_act;

endmodule

// File: tb/tb_check_sequencer.sv
// Scoreboard bench for check_sequencer: queued expected grants, independent monitor.
module tb_check_sequencer;
   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = $clog2(N);

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*W-1:0]   exp_data, act_data;
   logic             end_req;
   logic [N-1:0]     ack;
   logic             busy;
   logic [15:0]      check_count;
   logic [7:0]       fail_count;
   logic [IDW-1:0]   first_fail_id;
   logic [W-1:0]     first_fail_act;
   logic             done, passed;

   check_sequencer #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .req(req), .exp_data(exp_data), .act_data(act_data),
      .end_req(end_req), .ack(ack), .busy(busy), .check_count(check_count),
      .fail_count(fail_count), .first_fail_id(first_fail_id),
      .first_fail_act(first_fail_act), .done(done), .passed(passed)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // mode 0: check req->ack latency, 1: check 3-cycle spacing, 2: order only
   typedef struct { int id; int mode; } sb_t;
   sb_t sb[$];

   logic [W-1:0] q_exp[N][$], q_act[N][$];   // what each requester still has to present
   logic [W-1:0] ph_exp[N][$], ph_act[N][$]; // phase being built
   int drive_cyc = 0;
   int last_ack_cyc = 0;

   // reference model state
   int           m_ptr, m_checks, m_fails, m_ff_id;
   logic [W-1:0] m_ff_act;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic model_reset();
      m_ptr = N - 1; m_checks = 0; m_fails = 0; m_ff_id = 0; m_ff_act = '0;
   endtask

   task automatic model_note(input int id, input logic [W-1:0] e, input logic [W-1:0] a);
      if (m_checks < 65535) m_checks++;
      if (a !== e) begin
         if (m_fails == 0) begin m_ff_id = id; m_ff_act = a; end
         if (m_fails < 255) m_fails++;
      end
   endtask

   // Hand the built phase to the requesters and predict the round-robin grant order.
   task automatic schedule_phase();
      int pos[N];
      int left = 0;
      int first = 1;
      for (int i = 0; i < N; i++) begin
         pos[i] = 0;
         left += ph_exp[i].size();
         foreach (ph_exp[i][j]) begin
            q_exp[i].push_back(ph_exp[i][j]);
            q_act[i].push_back(ph_act[i][j]);
         end
      end
      while (left > 0) begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (pos[i] < ph_exp[i].size()) begin
               sb.push_back('{i, (first != 0) ? 0 : 1});
               model_note(i, ph_exp[i][pos[i]], ph_act[i][pos[i]]);
               pos[i]++; left--; m_ptr = i; first = 0;
               break;
            end
         end
      end
      for (int i = 0; i < N; i++) begin ph_exp[i].delete(); ph_act[i].delete(); end
   endtask

   task automatic clear_all();
      sb.delete();
      for (int i = 0; i < N; i++) begin q_exp[i].delete(); q_act[i].delete(); end
   endtask

   function automatic int pending();
      int n = sb.size();
      for (int i = 0; i < N; i++) n += q_exp[i].size();
      return n;
   endfunction

   task automatic wait_drain(input string nm, input int budget);
      int t = 0;
      while (pending() != 0 && t < budget) begin @(negedge clk); #1; t++; end
      chk({nm, "_drain_left"}, pending(), 0);
      if (pending() != 0) clear_all();
      @(negedge clk); @(negedge clk); #1;
   endtask

   task automatic check_stats(input string nm);
      chk({nm, "_check_count"}, check_count, m_checks);
      chk({nm, "_fail_count"}, fail_count, m_fails);
      chk({nm, "_first_fail_id"}, first_fail_id, m_ff_id);
      chk({nm, "_first_fail_act"}, first_fail_act, m_ff_act);
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (!done && t < 20) begin @(negedge clk); #1; t++; end
      chk({nm, "_done"}, done, 1);
      chk({nm, "_passed"}, passed, (m_fails == 0));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; clear_all(); model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic add(input int id, input logic [W-1:0] e, input logic [W-1:0] a);
      ph_exp[id].push_back(e); ph_act[id].push_back(a);
   endtask

   // Requester agents: present queue heads, retire one entry per ack.
   logic [N-1:0] a_nreq;
   initial begin
      req = '0; exp_data = '0; act_data = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int i = 0; i < N; i++)
               if (ack[i] && q_exp[i].size() > 0) begin
                  void'(q_exp[i].pop_front()); void'(q_act[i].pop_front());
               end
         end
         for (int i = 0; i < N; i++) begin
            a_nreq[i] = (q_exp[i].size() > 0);
            exp_data[i*W +: W] = a_nreq[i] ? q_exp[i][0] : '0;
            act_data[i*W +: W] = a_nreq[i] ? q_act[i][0] : '0;
         end
         if (req == '0 && a_nreq != '0) drive_cyc = cyc;
         req = a_nreq;
      end
   end

   // Monitor: every ack must match the next predicted grant.
   sb_t          mo_e;
   logic [N-1:0] mo_oh;
   initial forever begin
      @(negedge clk);
      if (ack != '0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got ack=%b want no ack", ack);
         end else begin
            mo_e = sb.pop_front();
            mo_oh = '0; mo_oh[mo_e.id] = 1'b1;
            if (ack !== mo_oh) begin
               errors++;
               $display("FAIL ack_id: got ack=%b want %b", ack, mo_oh);
            end
            if (mo_e.mode == 0) begin
               checks++;
               if (cyc - drive_cyc != 1) begin
                  errors++;
                  $display("FAIL ack_latency: got %0d want 1", cyc - drive_cyc);
               end
            end else if (mo_e.mode == 1) begin
               checks++;
               if (cyc - last_ack_cyc != 3) begin
                  errors++;
                  $display("FAIL ack_spacing: got %0d want 3", cyc - last_ack_cyc);
               end
            end
         end
         last_ack_cyc = cyc;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] te, ta;
   logic [N-1:0] tmask;
   int           tc;
   initial begin
      reset = 1'b1; end_req = 1'b0; model_reset();
      repeat (3) @(posedge clk); #1;
      chk("rst_ack", ack, 0);          chk("rst_busy", busy, 0);
      chk("rst_count", check_count, 0); chk("rst_fail", fail_count, 0);
      chk("rst_done", done, 0);        chk("rst_passed", passed, 0);
      chk("rst_ffid", first_fail_id, 0); chk("rst_ffact", first_fail_act, 0);
      reset = 1'b0;

      // single matching check, then close the run
      add(0, 8'h01, 8'h01); schedule_phase(); wait_drain("t1", 20);
      check_stats("t1"); chk("t1_busy", busy, 0);
      end_req = 1'b1; wait_done("t1"); end_req = 1'b0;
      do_reset();

      // all four held for two rounds
      for (int i = 0; i < N; i++) for (int j = 0; j < 2; j++) begin
         te = W'($urandom); add(i, te, te);
      end
      schedule_phase(); wait_drain("t2", 60); check_stats("t2");

      // two mismatches; the first one is remembered
      add(2, 8'hA5, 8'hA4); schedule_phase(); wait_drain("t3a", 20);
      add(1, 8'h3C, 8'h3D); schedule_phase(); wait_drain("t3b", 20); check_stats("t3");

      // 4-state operands
      te = 8'b0000000x; ta = 8'b0000000x; add(0, te, ta);
      schedule_phase(); wait_drain("t4a", 20); check_stats("t4a");
      te = 8'h00; ta = 8'b0000000z; add(3, te, ta);
      schedule_phase(); wait_drain("t4b", 20); check_stats("t4b");

      // random request sets, counts and data
      for (int p = 0; p < 25; p++) begin
         tmask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) if (tmask[i]) begin
            tc = $urandom_range(1, 3);
            for (int j = 0; j < tc; j++) begin
               te = W'($urandom);
               ta = ($urandom_range(0, 3) == 0) ? (te ^ W'($urandom_range(1, 255))) : te;
               add(i, te, ta);
            end
         end
         schedule_phase(); wait_drain("rand", 60);
         check_stats("rand");
      end

      // drive fail_count into saturation
      for (int i = 0; i < N; i++) for (int j = 0; j < 70; j++) begin
         te = W'($urandom); add(i, te, ~te);
      end
      schedule_phase(); wait_drain("sat", 4 * 70 * 3 + 50); check_stats("sat");
      end_req = 1'b1; wait_done("sat"); end_req = 1'b0;

      // reset while a grant is on the bus
      do_reset();
      add(0, 8'h11, 8'h11); schedule_phase(); wait_drain("t7a", 20);
      q_exp[1].push_back(8'h22); q_act[1].push_back(8'h22);
      q_exp[2].push_back(8'h33); q_act[2].push_back(8'h33);
      sb.push_back('{1, 0});
      tc = 0;
      while (sb.size() != 0 && tc < 20) begin @(negedge clk); #1; tc++; end
      chk("t7_grant_seen", sb.size(), 0);
      reset = 1'b1; clear_all(); model_reset();
      @(negedge clk); #1;
      chk("t7_ack_after_reset", ack, 0);
      chk("t7_count_after_reset", check_count, 0);
      reset = 1'b0;
      add(0, 8'h44, 8'h44); add(2, 8'h55, 8'h55); add(3, 8'h66, 8'h66);
      schedule_phase(); wait_drain("t7b", 40); check_stats("t7");

      // request and end_req together: request first, then DONE freezes everything
      do_reset();
      add(3, 8'h77, 8'h77); schedule_phase(); end_req = 1'b1;
      wait_drain("t8", 20); wait_done("t8"); check_stats("t8");
      q_exp[0].push_back(8'h01); q_act[0].push_back(8'h02);
      repeat (12) @(negedge clk); #1;
      chk("t8_frozen_count", check_count, m_checks);
      chk("t8_frozen_fail", fail_count, m_fails);
      chk("t8_still_done", done, 1);
      clear_all(); end_req = 1'b0;
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
